cache_arbiter: RTL

- Shares the single physical-memory line port between the instruction cache (read-only) and the data cache (read/write-back) of the rv32i pipeline.
- Sits between the two caches and pmem.
- Grants one line transaction at a time.
- Fixed priority to the data cache, with a bounded anti-starvation override for the instruction cache.
- Registers the pmem command, address and data.

---
 rtl/cache_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares the pmem line port between icache and dcache; the dcache wins unless
// the icache has waited STARVE_LIMIT grants. Macro CACHE_ARBITER_PERF_CNT_EN adds grant counters.
module cache_arbiter #(
  parameter int LINE_W       = 256,
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
`ifdef CACHE_ARBITER_PERF_CNT_EN
  output logic [31:0]       perf_i_grants,
  output logic [31:0]       perf_d_grants,
  output logic [31:0]       perf_conflicts,
`endif
  input  logic              pmem_resp
);
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

  state_t        state_reg;
  logic [SW-1:0] streak_reg;
  logic          d_req;
  logic          force_i;
  logic          grant_d;
  logic          grant_i;

  assign d_req   = d_read | d_write;
  assign force_i = (STARVE_LIMIT != 0) && i_read && (streak_reg == LIMIT);
  assign grant_d = d_req && !force_i;
  assign grant_i = i_read && !grant_d;

  // Both requesters see the raw pmem line; only their own resp pulse qualifies it.
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;
  assign i_resp  = (state_reg == SERVE_I) && pmem_resp;
  assign d_resp  = (state_reg == SERVE_D) && pmem_resp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      streak_reg   <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_d) begin
            state_reg    <= SERVE_D;
            pmem_address <= d_address;
            pmem_wdata   <= d_wdata;
            // A simultaneous read and write is serviced as a write-back.
            pmem_write   <= d_write;
            pmem_read    <= ~d_write;
            if (!i_read)
              streak_reg <= '0;
            else if (streak_reg != LIMIT)
              streak_reg <= streak_reg + SW'(1);
          end else if (grant_i) begin
            state_reg    <= SERVE_I;
            pmem_address <= i_address;
            pmem_wdata   <= '0;
            pmem_read    <= 1'b1;
            pmem_write   <= 1'b0;
            streak_reg   <= '0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            state_reg  <= DONE;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef CACHE_ARBITER_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_i_grants  <= '0;
      perf_d_grants  <= '0;
      perf_conflicts <= '0;
    end else if (state_reg == IDLE) begin
      if (grant_d)
        perf_d_grants <= perf_d_grants + 32'd1;
      if (grant_i)
        perf_i_grants <= perf_i_grants + 32'd1;
      if (i_read && d_req)
        perf_conflicts <= perf_conflicts + 32'd1;
    end
  end
`endif

`ifdef CACHE_ARBITER_RW_CHECK
  always_ff @(posedge clk) begin
    if (rst_n && (state_reg == IDLE) && d_read && d_write)
      $error("cache_arbiter: d_read and d_write asserted together");
  end
`endif

endmodule
